// File: rtl/rop3_req_sched.sv
// rop3_req_sched: round-robin front end that shares one ROP3 engine among
// NREQ requesters. It grants one request, streams its P, S and D words to
// the engine one per cycle, waits a bounded time for the engine result, and
// then returns that result on a shared response channel tagged with the ID.
module rop3_req_sched #(
    parameter int N       = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_p,
    input  logic [NREQ*N-1:0] req_s,
    input  logic [NREQ*N-1:0] req_d,
    input  logic [NREQ*8-1:0] req_mode,
    output logic              eng_load,
    output logic [1:0]        eng_sel,
    output logic [N-1:0]      eng_bitmap,
    output logic [7:0]        eng_mode,
    input  logic [N-1:0]      eng_result,
    input  logic              eng_valid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic [1:0]        rsp_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_P = 3'd1,
        SEND_S = 3'd2,
        SEND_D = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   last_grant;
    logic [7:0]       wait_cnt;

    logic             gnt_any;
    logic [IDW-1:0]   gnt_idx;
    logic [N-1:0]     sel_p;
    logic [N-1:0]     sel_s;
    logic [N-1:0]     sel_d;
    logic [7:0]       sel_mode;
    logic             sel_mode_ok;
    logic             wait_expired;

    logic [IDW-1:0]   id_q;
    logic [N-1:0]     p_q;
    logic [N-1:0]     s_q;
    logic [N-1:0]     d_q;
    logic [7:0]       mode_q;
    logic [N-1:0]     result_q;
    logic [1:0]       err_q;

    // The engine implements only this subset of the 256 ROP3 codes.
    function automatic logic mode_supported(input logic [7:0] m);
        logic ok;
        case (m)
            8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
            8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Round-robin pick: lowest requester above the last grant, else lowest overall.
    always_comb begin
        logic           hi_found;
        logic [IDW-1:0] hi_idx;
        logic           lo_found;
        logic [IDW-1:0] lo_idx;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
                if (IDW'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        gnt_any = lo_found;
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    // Route the candidate winner's operand set out of the packed request buses.
    always_comb begin
        sel_p    = '0;
        sel_s    = '0;
        sel_d    = '0;
        sel_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                sel_p    = req_p[i*N +: N];
                sel_s    = req_s[i*N +: N];
                sel_d    = req_d[i*N +: N];
                sel_mode = req_mode[i*8 +: 8];
            end
        end
        sel_mode_ok = mode_supported(sel_mode);
    end

    assign wait_expired = (wait_cnt == WAIT_LAST);

    // Control state: FSM register, round-robin pointer and WAIT cycle counter.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            wait_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gnt_any) begin
                last_grant <= gnt_idx;
            end
            if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Next-state logic; a result arriving on the last WAIT cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = sel_mode_ok ? SEND_P : RESP;
                end
            end
            SEND_P: state_d = SEND_S;
            SEND_S: state_d = SEND_D;
            SEND_D: state_d = WAIT;
            WAIT: begin
                if (eng_valid || wait_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath capture: operands at grant, result/error when the job finishes.
    // Outputs are gated by state, so these registers need no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && gnt_any) begin
            id_q   <= gnt_idx;
            p_q    <= sel_p;
            s_q    <= sel_s;
            d_q    <= sel_d;
            mode_q <= sel_mode;
            if (!sel_mode_ok) begin
                result_q <= '0;
                err_q    <= 2'b01;
            end
        end
        if (state_q == WAIT) begin
            if (eng_valid) begin
                result_q <= eng_result;
                err_q    <= 2'b00;
            end else if (wait_expired) begin
                result_q <= '0;
                err_q    <= 2'b10;
            end
        end
    end

    // Output decode; everything idles at zero, including while reset is held.
    always_comb begin
        req_ready  = '0;
        eng_load   = 1'b0;
        eng_sel    = 2'd0;
        eng_bitmap = '0;
        eng_mode   = '0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_result = '0;
        rsp_err    = 2'b00;
        case (state_q)
            IDLE: begin
                if (gnt_any && srst_n) begin
                    req_ready = NREQ'(1) << gnt_idx;
                end
            end
            SEND_P: begin
                eng_load   = 1'b1;
                eng_sel    = 2'd1;
                eng_bitmap = p_q;
                eng_mode   = mode_q;
            end
            SEND_S: begin
                eng_load   = 1'b1;
                eng_sel    = 2'd2;
                eng_bitmap = s_q;
                eng_mode   = mode_q;
            end
            SEND_D: begin
                eng_load   = 1'b1;
                eng_sel    = 2'd3;
                eng_bitmap = d_q;
                eng_mode   = mode_q;
            end
            WAIT: begin
                eng_mode = mode_q;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_id     = id_q;
                rsp_result = result_q;
                rsp_err    = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rop3_req_sched.sv
// Bench for rop3_req_sched: the bench plays both the requesters and the ROP3
// engine, and predicts grants, engine traffic and responses from a simple
// transaction-level model (round-robin pointer + truth-table ROP3).
module tb_rop3_req_sched;

    localparam int N       = 8;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 15;
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              clk = 1'b0;
    logic              srst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_p;
    logic [NREQ*N-1:0] req_s;
    logic [NREQ*N-1:0] req_d;
    logic [NREQ*8-1:0] req_mode;
    logic              eng_load;
    logic [1:0]        eng_sel;
    logic [N-1:0]      eng_bitmap;
    logic [7:0]        eng_mode;
    logic [N-1:0]      eng_result;
    logic              eng_valid;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;
    logic [1:0]        rsp_err;

    logic [N-1:0] rp [NREQ];
    logic [N-1:0] rs [NREQ];
    logic [N-1:0] rd [NREQ];
    logic [7:0]   rm [NREQ];

    int checks   = 0;
    int failures = 0;
    int rr_last  = NREQ - 1;

    byte unsigned sup_list [15] = '{8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
                                    8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF};

    rop3_req_sched #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .srst_n     (srst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_p      (req_p),
        .req_s      (req_s),
        .req_d      (req_d),
        .req_mode   (req_mode),
        .eng_load   (eng_load),
        .eng_sel    (eng_sel),
        .eng_bitmap (eng_bitmap),
        .eng_mode   (eng_mode),
        .eng_result (eng_result),
        .eng_valid  (eng_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_p    = '0;
        req_s    = '0;
        req_d    = '0;
        req_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_p[i*N +: N]    = rp[i];
            req_s[i*N +: N]    = rs[i];
            req_d[i*N +: N]    = rd[i];
            req_mode[i*8 +: 8] = rm[i];
        end
    end

    function automatic bit is_sup(input logic [7:0] m);
        foreach (sup_list[i]) if (sup_list[i] == m) return 1'b1;
        return 1'b0;
    endfunction

    // ROP3 truth table: output bit = mode bit indexed by {P,S,D}.
    function automatic logic [N-1:0] rop(input logic [N-1:0] p, input logic [N-1:0] s,
                                         input logic [N-1:0] d, input logic [7:0] m);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m[{p[i], s[i], d[i]}];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_load"}, eng_load, 0);
        chk({tag, "_sel"}, eng_sel, 0);
        chk({tag, "_bitmap"}, eng_bitmap, 0);
        chk({tag, "_mode"}, eng_mode, 0);
        chk({tag, "_rvalid"}, rsp_valid, 0);
        chk({tag, "_rid"}, rsp_id, 0);
        chk({tag, "_rres"}, rsp_result, 0);
        chk({tag, "_rerr"}, rsp_err, 0);
    endtask

    // One full transaction starting on a negedge with the DUT idle and
    // req_valid/operands already driven. dly = WAIT cycle (1-based) on which the
    // engine answers, 0 = never. hold = cycles rsp_ready is kept low in RESP.
    task automatic txn(input int dly, input int hold, input bit drop);
        int g;
        int kend;
        int lat;
        logic [N-1:0] P, S, D, er;
        logic [7:0] M;
        logic [1:0] ee;
        g = -1;
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = (rr_last + i) % NREQ;
            if (g < 0 && req_valid[j]) g = j;
        end
        #1;
        if (g < 0) begin
            chk("txn_no_request", 1, 0);
            return;
        end
        chk("grant_ready", req_ready, 1 << g);
        chk("grant_load", eng_load, 0);
        chk("grant_rvalid", rsp_valid, 0);
        P = rp[g]; S = rs[g]; D = rd[g]; M = rm[g];
        rr_last = g;
        lat = 0;
        @(negedge clk);
        lat++;
        if (drop) req_valid[g] = 1'b0;
        if (is_sup(M)) begin
            chk("sp_load", eng_load, 1);
            chk("sp_sel", eng_sel, 1);
            chk("sp_bitmap", eng_bitmap, P);
            chk("sp_mode", eng_mode, M);
            chk("sp_ready", req_ready, 0);
            eng_valid = 1'($urandom);
            eng_result = N'($urandom);
            @(negedge clk);
            lat++;
            chk("ss_sel", eng_sel, 2);
            chk("ss_bitmap", eng_bitmap, S);
            chk("ss_load", eng_load, 1);
            eng_valid = 1'($urandom);
            @(negedge clk);
            lat++;
            chk("sd_sel", eng_sel, 3);
            chk("sd_bitmap", eng_bitmap, D);
            chk("sd_mode", eng_mode, M);
            eng_valid = 1'($urandom);
            kend = (dly >= 1 && dly <= TIMEOUT) ? dly : TIMEOUT;
            for (int k = 1; k <= kend; k++) begin
                @(negedge clk);
                lat++;
                chk("wait_load", eng_load, 0);
                chk("wait_sel", eng_sel, 0);
                chk("wait_mode", eng_mode, M);
                chk("wait_rvalid", rsp_valid, 0);
                eng_valid  = (k == dly);
                eng_result = (k == dly) ? rop(P, S, D, M) : N'($urandom);
            end
            if (dly >= 1 && dly <= TIMEOUT) begin
                er = rop(P, S, D, M);
                ee = 2'b00;
            end else begin
                er = '0;
                ee = 2'b10;
            end
            @(negedge clk);
            lat++;
            eng_valid = 1'b0;
            chk("resp_latency", lat, 4 + kend);
        end else begin
            er = '0;
            ee = 2'b01;
        end
        chk("resp_valid", rsp_valid, 1);
        chk("resp_id", rsp_id, g);
        chk("resp_result", rsp_result, er);
        chk("resp_err", rsp_err, ee);
        chk("resp_load", eng_load, 0);
        for (int h = 0; h < hold; h++) begin
            eng_valid = 1'($urandom);
            eng_result = N'($urandom);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, g);
            chk("hold_result", rsp_result, er);
            chk("hold_err", rsp_err, ee);
            chk("hold_ready", req_ready, 0);
            chk("hold_load", eng_load, 0);
        end
        eng_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_rvalid", rsp_valid, 0);
        chk("done_load", eng_load, 0);
    endtask

    task automatic set_req(input int i, input logic [7:0] p, input logic [7:0] s,
                           input logic [7:0] d, input logic [7:0] m);
        rp[i] = N'(p); rs[i] = N'(s); rd[i] = N'(d); rm[i] = m;
    endtask

    initial begin
        srst_n     = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        eng_valid  = 1'b0;
        eng_result = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state, including a pending request held during reset.
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        chk_quiet_outputs("reset");
        req_valid = '0;
        @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);

        // Single request with the reference operand set.
        set_req(0, 8'hF0, 8'hCC, 8'hAA, 8'hC0);
        req_valid = 2'b01;
        txn(1, 0, 1'b1);

        // Unsupported mode from requester 1: no engine traffic.
        set_req(1, 8'h5A, 8'h3C, 8'h99, 8'h12);
        req_valid = 2'b10;
        txn(1, 0, 1'b1);

        // Both requesters held valid for four operations: grants alternate.
        set_req(0, 8'h12, 8'h34, 8'h56, 8'h66);
        set_req(1, 8'h9A, 8'hBC, 8'hDE, 8'hEE);
        req_valid = 2'b11;
        for (int op = 0; op < 4; op++) txn(2 + op, 0, 1'b0);

        // Engine never answers, with the response back-pressured for 10 cycles.
        set_req(0, 8'h0F, 8'hF0, 8'h33, 8'h88);
        txn(0, 10, 1'b0);
        req_valid = '0;

        // Result arriving on the very last WAIT cycle beats the timeout.
        set_req(1, 8'hA5, 8'h5A, 8'hFF, 8'hFB);
        req_valid = 2'b10;
        txn(TIMEOUT, 0, 1'b1);

        // Reset pulsed during SEND_S of a requester-1 job.
        set_req(1, 8'h11, 8'h22, 8'h44, 8'hCC);
        req_valid = 2'b10;
        #1;
        chk("rst_grant", req_ready, 2'b10);
        @(negedge clk);
        chk("rst_sp_sel", eng_sel, 1);
        @(negedge clk);
        chk("rst_ss_sel", eng_sel, 2);
        chk("rst_ss_bitmap", eng_bitmap, 8'h22);
        srst_n = 1'b0;
        #1;
        chk_quiet_outputs("midrst");
        eng_valid  = 1'b1;
        eng_result = 8'h77;
        @(negedge clk);
        chk_quiet_outputs("midrst_hold");
        srst_n  = 1'b1;
        rr_last = NREQ - 1;
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_rvalid", rsp_valid, 0);
        chk("post_rst_load", eng_load, 0);
        eng_valid = 1'b0;
        set_req(0, 8'h3C, 8'hC3, 8'h0F, 8'h5A);
        set_req(1, 8'hFF, 8'h00, 8'hFF, 8'hF0);
        req_valid = 2'b11;
        txn(3, 1, 1'b1);
        req_valid = '0;
        @(negedge clk);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            int sel;
            int dly;
            for (int i = 0; i < NREQ; i++) begin
                logic [7:0] m;
                if ($urandom_range(0, 2) != 0) m = sup_list[$urandom_range(0, 14)];
                else m = 8'($urandom);
                set_req(i, 8'($urandom), 8'($urandom), 8'($urandom), m);
            end
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            sel = $urandom_range(0, 7);
            if (sel == 0) dly = 0;
            else if (sel == 1) dly = TIMEOUT;
            else dly = $urandom_range(1, 5);
            txn(dly, $urandom_range(0, 3), 1'($urandom));
            req_valid = '0;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
